hit_detect_scan: RTL and testbench

Sequential collision checker between the bullet/movement block and the game-state logic. Once per game tick it scans every active player bullet against every live enemy, and every active enemy bullet against the player. It returns hit masks that upstream uses to retire bullets and kill objects. Work is time-multiplexed: one bullet per clock, compared in parallel against all targets, which keeps comparator count low.

---
 rtl/hit_detect_scan.sv | 194 +++++++++++++++++++
 tb/tb_hit_detect_scan.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_detect_scan.sv
// Time-multiplexed collision scanner: one bullet per clock against all targets.
// Optional enemy-bullet/player pass is built only when HIT_PLAYER_SCAN_EN is defined.
module hit_detect_scan #(
   parameter int N_ENEMY   = 15,
   parameter int N_PBULLET = 16,
   parameter int N_EBULLET = 30,
   parameter int ENEMY_W   = 32,
   parameter int ENEMY_H   = 24,
   parameter int PLAYER_W  = 32,
   parameter int PLAYER_H  = 24,
   parameter int BULLET_W  = 6,
   parameter int BULLET_H  = 20
) (
   input  logic                    i_Clk,
   input  logic                    i_Rst,
   input  logic                    i_fStart,
   input  logic [19*N_PBULLET-1:0] i_PlayerBulletPos,
   input  logic [N_PBULLET-1:0]    i_PlayerBulletState,
   input  logic [19*N_ENEMY-1:0]   i_EnemyPos,
   input  logic [N_ENEMY-1:0]      i_EnemyState,
   input  logic [19*N_EBULLET-1:0] i_EnemyBulletPos,
   input  logic [N_EBULLET-1:0]    i_EnemyBulletState,
   input  logic [18:0]             i_PlayerPos,
   input  logic                    i_PlayerState,
   output logic                    o_fBusy,
   output logic                    o_fDone,
   output logic [N_ENEMY-1:0]      o_EnemyHit,
   output logic [N_PBULLET-1:0]    o_PlayerBulletHit,
   output logic [N_EBULLET-1:0]    o_EnemyBulletHit,
   output logic                    o_fPlayerHit
);

   localparam logic [18:0] DEAD_POS = 19'h7FFFF;
   localparam int MAX_N = (N_PBULLET > N_EBULLET) ? N_PBULLET : N_EBULLET;
   localparam int IDX_W = $clog2(MAX_N + 1);

   typedef enum logic [1:0] {IDLE, SCAN_PB, SCAN_EB, DONE} state_t;

   state_t             state, stateNext;
   logic [IDX_W-1:0]   idx, idxNext;

   logic [18:0]        pbPos;
   logic               pbActive;
   logic               pbLive;
   logic               pbFound;
   logic [N_ENEMY-1:0] enemyKill;
   logic [N_PBULLET-1:0] pbConsume;

   // Widened coordinates keep x+w and y+h from wrapping at the screen edge.
   function automatic logic overlap(input logic [18:0] aPos, input logic [10:0] aW,
                                    input logic [9:0] aH, input logic [18:0] bPos,
                                    input logic [10:0] bW, input logic [9:0] bH);
      logic [10:0] ax, bx;
      logic [9:0]  ay, by;
      ax = {1'b0, aPos[18:9]};
      bx = {1'b0, bPos[18:9]};
      ay = {1'b0, aPos[8:0]};
      by = {1'b0, bPos[8:0]};
      return (ax < bx + bW) && (bx < ax + aW) && (ay < by + bH) && (by < ay + aH);
   endfunction

   always_comb begin
      stateNext = state;
      idxNext   = idx;
      case (state)
         IDLE: begin
            if (i_fStart) begin
               stateNext = SCAN_PB;
               idxNext   = '0;
            end
         end
         SCAN_PB: begin
            if (idx == IDX_W'(N_PBULLET - 1)) begin
               idxNext = '0;
`ifdef HIT_PLAYER_SCAN_EN
               stateNext = SCAN_EB;
`else
               stateNext = DONE;
`endif
            end else begin
               idxNext = idx + IDX_W'(1);
            end
         end
`ifdef HIT_PLAYER_SCAN_EN
         SCAN_EB: begin
            if (idx == IDX_W'(N_EBULLET - 1)) begin
               idxNext   = '0;
               stateNext = DONE;
            end else begin
               idxNext = idx + IDX_W'(1);
            end
         end
`endif
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Current player bullet against every enemy; lowest-numbered qualifying enemy wins.
   always_comb begin
      pbPos    = DEAD_POS;
      pbActive = 1'b0;
      for (int k = 0; k < N_PBULLET; k++) begin
         if (idx == IDX_W'(k)) begin
            pbPos    = i_PlayerBulletPos[19*k +: 19];
            pbActive = i_PlayerBulletState[k];
         end
      end
      pbLive    = pbActive && (pbPos != DEAD_POS);
      enemyKill = '0;
      pbFound   = 1'b0;
      for (int e = 0; e < N_ENEMY; e++) begin
         if (!pbFound && pbLive && i_EnemyState[e] && !o_EnemyHit[e] &&
             (i_EnemyPos[19*e +: 19] != DEAD_POS) &&
             overlap(pbPos, 11'(BULLET_W), 10'(BULLET_H),
                     i_EnemyPos[19*e +: 19], 11'(ENEMY_W), 10'(ENEMY_H))) begin
            enemyKill[e] = 1'b1;
            pbFound      = 1'b1;
         end
      end
      pbConsume = '0;
      for (int k = 0; k < N_PBULLET; k++) begin
         if (idx == IDX_W'(k)) pbConsume[k] = pbFound;
      end
   end

`ifdef HIT_PLAYER_SCAN_EN
   logic [18:0]          ebPos;
   logic                 ebActive;
   logic                 ebStrike;
   logic [N_EBULLET-1:0] ebConsume;

   always_comb begin
      ebPos    = DEAD_POS;
      ebActive = 1'b0;
      for (int k = 0; k < N_EBULLET; k++) begin
         if (idx == IDX_W'(k)) begin
            ebPos    = i_EnemyBulletPos[19*k +: 19];
            ebActive = i_EnemyBulletState[k];
         end
      end
      ebStrike = ebActive && (ebPos != DEAD_POS) && i_PlayerState &&
                 (i_PlayerPos != DEAD_POS) &&
                 overlap(ebPos, 11'(BULLET_W), 10'(BULLET_H),
                         i_PlayerPos, 11'(PLAYER_W), 10'(PLAYER_H));
      ebConsume = '0;
      for (int k = 0; k < N_EBULLET; k++) begin
         if (idx == IDX_W'(k)) ebConsume[k] = ebStrike;
      end
   end
`else
   logic unusedInputs;
   assign unusedInputs     = ^{i_EnemyBulletPos, i_EnemyBulletState, i_PlayerPos, i_PlayerState};
   assign o_EnemyBulletHit = '0;
   assign o_fPlayerHit     = 1'b0;
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state             <= IDLE;
         idx               <= '0;
         o_fBusy           <= 1'b0;
         o_fDone           <= 1'b0;
         o_EnemyHit        <= '0;
         o_PlayerBulletHit <= '0;
`ifdef HIT_PLAYER_SCAN_EN
         o_EnemyBulletHit  <= '0;
         o_fPlayerHit      <= 1'b0;
`endif
      end else begin
         state   <= stateNext;
         idx     <= idxNext;
         o_fBusy <= (state == SCAN_PB) || (state == SCAN_EB);
         o_fDone <= (state == DONE);
         if ((state == IDLE) && i_fStart) begin
            o_EnemyHit        <= '0;
            o_PlayerBulletHit <= '0;
`ifdef HIT_PLAYER_SCAN_EN
            o_EnemyBulletHit  <= '0;
            o_fPlayerHit      <= 1'b0;
`endif
         end else if (state == SCAN_PB) begin
            o_EnemyHit        <= o_EnemyHit | enemyKill;
            o_PlayerBulletHit <= o_PlayerBulletHit | pbConsume;
`ifdef HIT_PLAYER_SCAN_EN
         end else if (state == SCAN_EB) begin
            o_EnemyBulletHit <= o_EnemyBulletHit | ebConsume;
            if (ebStrike) o_fPlayerHit <= 1'b1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_hit_detect_scan.sv
// Bench for hit_detect_scan: directed vector table, corner sequences and a random
// run against a box-overlap reference model.
module tb_hit_detect_scan;

`ifdef HIT_PLAYER_SCAN_EN
   localparam bit HAS_EB = 1'b1;
`else
   localparam bit HAS_EB = 1'b0;
`endif
   localparam int LAT = HAS_EB ? 47 : 17;
   localparam logic [18:0] DEAD = 19'h7FFFF;

   logic i_Clk = 1'b0;
   logic i_Rst = 1'b1;
   logic i_fStart = 1'b0;

   logic [18:0] pbPos[16];
   logic [18:0] enPos[15];
   logic [18:0] ebPos[30];
   logic [15:0] pbSt;
   logic [14:0] enSt;
   logic [29:0] ebSt;
   logic [18:0] plPos;
   logic        plSt;

   logic [19*16-1:0] pbVec;
   logic [19*15-1:0] enVec;
   logic [19*30-1:0] ebVec;

   logic        o_fBusy, o_fDone, o_fPlayerHit;
   logic [14:0] o_EnemyHit;
   logic [15:0] o_PlayerBulletHit;
   logic [29:0] o_EnemyBulletHit;

   int nChecks = 0;
   int nFail   = 0;
   string curTag = "init";

   always #5 i_Clk = ~i_Clk;

   always_comb begin
      pbVec = '0;
      enVec = '0;
      ebVec = '0;
      for (int k = 0; k < 16; k++) pbVec[19*k +: 19] = pbPos[k];
      for (int k = 0; k < 15; k++) enVec[19*k +: 19] = enPos[k];
      for (int k = 0; k < 30; k++) ebVec[19*k +: 19] = ebPos[k];
   end

   hit_detect_scan dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_fStart(i_fStart),
      .i_PlayerBulletPos(pbVec), .i_PlayerBulletState(pbSt),
      .i_EnemyPos(enVec), .i_EnemyState(enSt),
      .i_EnemyBulletPos(ebVec), .i_EnemyBulletState(ebSt),
      .i_PlayerPos(plPos), .i_PlayerState(plSt),
      .o_fBusy(o_fBusy), .o_fDone(o_fDone), .o_EnemyHit(o_EnemyHit),
      .o_PlayerBulletHit(o_PlayerBulletHit), .o_EnemyBulletHit(o_EnemyBulletHit),
      .o_fPlayerHit(o_fPlayerHit)
   );

   typedef struct {
      int pbA, pbAx, pbAy, pbB, pbBx, pbBy;
      int en, enX, enY, eb, ebX, ebY, plX, plY;
      bit plAlive;
      logic [14:0] expEn;
      logic [15:0] expPb;
      logic [29:0] expEb;
      bit expPl;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s/%s: actual %0h required %0h", curTag, name, act, exp);
      end
   endtask

   function automatic logic [18:0] pk(input int x, input int y);
      logic [31:0] xv, yv;
      xv = x;
      yv = y;
      return {xv[9:0], yv[8:0]};
   endfunction

   function automatic bit boxHit(input logic [18:0] a, input int aw, input int ah,
                                 input logic [18:0] b, input int bw, input int bh);
      int ax, ay, bx, by;
      ax = int'(a[18:9]); ay = int'(a[8:0]);
      bx = int'(b[18:9]); by = int'(b[8:0]);
      return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
   endfunction

   // Reference: bullets visited in order, each takes the lowest still-standing enemy it touches.
   task automatic model(output logic [14:0] eEn, output logic [15:0] ePb,
                        output logic [29:0] eEb, output logic ePl);
      eEn = '0; ePb = '0; eEb = '0; ePl = 1'b0;
      for (int p = 0; p < 16; p++) begin
         if (pbSt[p] && pbPos[p] != DEAD) begin
            for (int e = 0; e < 15; e++) begin
               if (enSt[e] && enPos[e] != DEAD && !eEn[e] &&
                   boxHit(pbPos[p], 6, 20, enPos[e], 32, 24)) begin
                  eEn[e] = 1'b1;
                  ePb[p] = 1'b1;
                  break;
               end
            end
         end
      end
      if (HAS_EB) begin
         for (int q = 0; q < 30; q++) begin
            if (ebSt[q] && ebPos[q] != DEAD && plSt && plPos != DEAD &&
                boxHit(ebPos[q], 6, 20, plPos, 32, 24)) begin
               eEb[q] = 1'b1;
               ePl = 1'b1;
            end
         end
      end
   endtask

   task automatic clearObjects();
      for (int k = 0; k < 16; k++) pbPos[k] = '0;
      for (int k = 0; k < 15; k++) enPos[k] = '0;
      for (int k = 0; k < 30; k++) ebPos[k] = '0;
      pbSt = '0; enSt = '0; ebSt = '0;
      plPos = pk(500, 400);
      plSt = 1'b0;
   endtask

   task automatic applyVec(input vec_t r);
      clearObjects();
      if (r.pbA >= 0) begin pbPos[r.pbA] = pk(r.pbAx, r.pbAy); pbSt[r.pbA] = 1'b1; end
      if (r.pbB >= 0) begin pbPos[r.pbB] = pk(r.pbBx, r.pbBy); pbSt[r.pbB] = 1'b1; end
      if (r.en >= 0)  begin enPos[r.en] = pk(r.enX, r.enY);    enSt[r.en] = 1'b1; end
      if (r.eb >= 0)  begin ebPos[r.eb] = pk(r.ebX, r.ebY);    ebSt[r.eb] = 1'b1; end
      plPos = pk(r.plX, r.plY);
      plSt  = r.plAlive;
   endtask

   task automatic runScan();
      int firstDone;
      int dones;
      firstDone = -1;
      dones = 0;
      @(negedge i_Clk);
      i_fStart = 1'b1;
      @(negedge i_Clk);
      i_fStart = 1'b0;
      chk("busyAfterE0", 64'(o_fBusy), 64'(0));
      for (int k = 1; k <= LAT + 5; k++) begin
         @(negedge i_Clk);
         if (k == 1) chk("busyAfterE1", 64'(o_fBusy), 64'(1));
         if (o_fDone) begin
            dones++;
            if (firstDone < 0) firstDone = k;
            chk("busyInDone", 64'(o_fBusy), 64'(0));
         end
      end
      chk("doneLatency", 64'(firstDone), 64'(LAT));
      chk("doneCount", 64'(dones), 64'(1));
   endtask

   task automatic checkMasks(input logic [14:0] eEn, input logic [15:0] ePb,
                             input logic [29:0] eEb, input logic ePl);
      chk("enemyHit", 64'(o_EnemyHit), 64'(eEn));
      chk("pbHit", 64'(o_PlayerBulletHit), 64'(ePb));
      chk("ebHit", 64'(o_EnemyBulletHit), 64'(eEb));
      chk("playerHit", 64'(o_fPlayerHit), 64'(ePl));
   endtask

   initial begin
      logic [14:0] mEn;
      logic [15:0] mPb;
      logic [29:0] mEb;
      logic        mPl;
      int dones;

      tbl[0]  = '{3, 100, 200, -1, 0, 0, 7, 95, 190, -1, 0, 0, 500, 400, 1'b1, 15'h0080, 16'h0008, 30'h0, 1'b0};
      tbl[1]  = '{0, 100, 200, 1, 100, 200, 2, 95, 190, -1, 0, 0, 500, 400, 1'b1, 15'h0004, 16'h0001, 30'h0, 1'b0};
      tbl[2]  = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 29, 310, 380, 302, 372, 1'b1, 15'h0, 16'h0, 30'h20000000, 1'b1};
      tbl[3]  = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 29, 310, 380, 302, 372, 1'b0, 15'h0, 16'h0, 30'h0, 1'b0};
      tbl[4]  = '{0, 232, 100, -1, 0, 0, 4, 200, 100, -1, 0, 0, 500, 400, 1'b1, 15'h0, 16'h0, 30'h0, 1'b0};
      tbl[5]  = '{0, 231, 100, -1, 0, 0, 4, 200, 100, -1, 0, 0, 500, 400, 1'b1, 15'h0010, 16'h0001, 30'h0, 1'b0};
      tbl[6]  = '{0, 194, 100, -1, 0, 0, 4, 200, 100, -1, 0, 0, 500, 400, 1'b1, 15'h0, 16'h0, 30'h0, 1'b0};
      tbl[7]  = '{0, 200, 124, -1, 0, 0, 4, 200, 100, -1, 0, 0, 500, 400, 1'b1, 15'h0, 16'h0, 30'h0, 1'b0};
      tbl[8]  = '{5, 210, 123, -1, 0, 0, 4, 200, 100, -1, 0, 0, 500, 400, 1'b1, 15'h0010, 16'h0020, 30'h0, 1'b0};
      tbl[9]  = '{0, 1023, 511, -1, 0, 0, 0, 1000, 500, -1, 0, 0, 500, 400, 1'b1, 15'h0, 16'h0, 30'h0, 1'b0};
      tbl[10] = '{0, 1020, 505, -1, 0, 0, 0, 1023, 511, -1, 0, 0, 500, 400, 1'b1, 15'h0, 16'h0, 30'h0, 1'b0};
      tbl[11] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 0, 1023, 511, 1000, 500, 1'b1, 15'h0, 16'h0, 30'h0, 1'b0};
      tbl[12] = '{15, 1018, 495, -1, 0, 0, 14, 1020, 500, -1, 0, 0, 500, 400, 1'b1, 15'h4000, 16'h8000, 30'h0, 1'b0};
      tbl[13] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 5, 310, 353, 302, 372, 1'b1, 15'h0, 16'h0, 30'h00000020, 1'b1};
      tbl[14] = '{-1, 0, 0, -1, 0, 0, -1, 0, 0, 0, 296, 372, 302, 372, 1'b1, 15'h0, 16'h0, 30'h0, 1'b0};

      clearObjects();
      repeat (3) @(negedge i_Clk);
      i_Rst = 1'b0;
      curTag = "reset";
      chk("busy", 64'(o_fBusy), 64'(0));
      chk("done", 64'(o_fDone), 64'(0));
      checkMasks('0, '0, '0, 1'b0);

      curTag = "empty";
      runScan();
      checkMasks('0, '0, '0, 1'b0);

      for (int i = 0; i < 15; i++) begin
         curTag = $sformatf("vec%0d", i);
         applyVec(tbl[i]);
         runScan();
         checkMasks(tbl[i].expEn, tbl[i].expPb,
                    HAS_EB ? tbl[i].expEb : 30'h0, HAS_EB ? tbl[i].expPl : 1'b0);
      end

      // Reset in the middle of a scan that already has a hit recorded.
      curTag = "midReset";
      applyVec(tbl[0]);
      @(negedge i_Clk);
      i_fStart = 1'b1;
      @(negedge i_Clk);
      i_fStart = 1'b0;
      repeat (20) @(negedge i_Clk);
      i_Rst = 1'b1;
      @(negedge i_Clk);
      i_Rst = 1'b0;
      chk("busy", 64'(o_fBusy), 64'(0));
      checkMasks('0, '0, '0, 1'b0);
      dones = 0;
      for (int k = 0; k < LAT + 20; k++) begin
         @(negedge i_Clk);
         if (o_fDone) dones++;
      end
      chk("noDone", 64'(dones), 64'(0));
      checkMasks('0, '0, '0, 1'b0);

      // Start re-pulsed throughout the scan and on the DONE edge.
      curTag = "restart";
      applyVec(tbl[1]);
      @(negedge i_Clk);
      i_fStart = 1'b1;
      @(negedge i_Clk);
      dones = 0;
      for (int k = 1; k <= LAT + 40; k++) begin
         i_fStart = (((k % 5) == 0) || (k == LAT)) && (k <= LAT);
         @(negedge i_Clk);
         if (o_fDone) begin
            dones++;
            chk("doneEdge", 64'(k), 64'(LAT));
         end
      end
      i_fStart = 1'b0;
      chk("doneCount", 64'(dones), 64'(1));
      checkMasks(15'h0004, 16'h0001, '0, 1'b0);

      for (int it = 0; it < 30; it++) begin
         curTag = $sformatf("rand%0d", it);
         for (int k = 0; k < 16; k++) begin
            pbPos[k] = ($urandom_range(15, 0) == 0) ? DEAD
                     : pk(int'($urandom_range(300, 100)), int'($urandom_range(250, 100)));
            pbSt[k] = 1'($urandom_range(1, 0));
         end
         for (int k = 0; k < 15; k++) begin
            enPos[k] = ($urandom_range(15, 0) == 0) ? DEAD
                     : pk(int'($urandom_range(300, 90)), int'($urandom_range(250, 90)));
            enSt[k] = 1'($urandom_range(1, 0));
         end
         for (int k = 0; k < 30; k++) begin
            ebPos[k] = ($urandom_range(15, 0) == 0) ? DEAD
                     : pk(int'($urandom_range(300, 100)), int'($urandom_range(250, 100)));
            ebSt[k] = 1'($urandom_range(1, 0));
         end
         plPos = pk(int'($urandom_range(280, 120)), int'($urandom_range(230, 120)));
         plSt  = ($urandom_range(3, 0) != 0);
         model(mEn, mPb, mEb, mPl);
         runScan();
         checkMasks(mEn, mPb, mEb, mPl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
